// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage 64-bit core.
//
// Resolves three pipeline hazards:
//   - Load-use: one-cycle stall of PC and IF/ID, plus a bubble into ID/EX.
//   - Taken branch/jump resolved in MEM: flush IF/ID, ID/EX and EX/MEM.
//   - Data-memory wait: full freeze, with a watchdog that latches a sticky
//     error after TIMEOUT consecutive busy cycles.
// Also keeps two saturating performance counters (stall cycles, branch flushes).
//
// Parameters:
//   TIMEOUT  consecutive dmem_busy cycles that trigger the watchdog (>=1)
//   CNT_W    performance counter width
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   idex_mem_read, idex_rd        load flag / destination reg of EX instruction
//   ifid_rs1, ifid_rs2            source regs of ID instruction
//   branch_taken                  branch in MEM resolved taken
//   dmem_busy                     data memory cannot complete this cycle
//   pc_write, *_write, *_flush    stage register enables / clears (combinational)
//   mem_timeout                   sticky watchdog error flag
//   stall_count, flush_count      saturating performance counters
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             branch_taken,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_ERROR
   } state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [WW-1:0] busy_seen;
   logic          load_use;
   logic          stall_inc, flush_inc, timeout_set;

   assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

   // Busy cycles already elapsed before this one; a fresh wait starts at zero.
   assign busy_seen = (state == ST_MEM_WAIT) ? wait_cnt : '0;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      exmem_flush = 1'b0;
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      timeout_set = 1'b0;

      case (state)
         ST_RUN, ST_MEM_WAIT: begin
            if (dmem_busy) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_write  = 1'b0;
               exmem_write = 1'b0;
               stall_inc   = 1'b1;
               // This is the (busy_seen+1)-th consecutive busy cycle.
               if (busy_seen == WAIT_LAST) begin
                  state_nxt   = ST_ERROR;
                  wait_nxt    = '0;
                  timeout_set = 1'b1;
               end else begin
                  state_nxt = ST_MEM_WAIT;
                  wait_nxt  = busy_seen + 1'b1;
               end
            end else begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else if (load_use) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
                  stall_inc  = 1'b1;
               end
            end
         end
         default: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_nxt   = ST_ERROR;
         end
      endcase

      // Hold every stage register while reset is asserted.
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b0;
         idex_write  = 1'b0;
         idex_flush  = 1'b0;
         exmem_write = 1'b0;
         exmem_flush = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (timeout_set)
            mem_timeout <= 1'b1;
         if (stall_inc && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if (flush_inc && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Each stimulus cycle pushes the hand-computed outputs expected in that cycle;
// an independent monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   // Control vector order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f
   localparam logic [6:0] C_DEF = 7'b1101010;
   localparam logic [6:0] C_FRZ = 7'b0000000;
   localparam logic [6:0] C_LU  = 7'b0001110;
   localparam logic [6:0] C_BR  = 7'b1111111;

   typedef struct {
      logic [6:0]    ctrl;
      logic          to;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
      int            id;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          idex_mem_read = 1'b0;
   logic [4:0]    idex_rd = '0;
   logic [4:0]    ifid_rs1 = '0;
   logic [4:0]    ifid_rs2 = '0;
   logic          branch_taken = 1'b0;
   logic          dmem_busy = 1'b0;
   logic          pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic          exmem_write, exmem_flush, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .idex_mem_read(idex_mem_read),
      .idex_rd      (idex_rd),
      .ifid_rs1     (ifid_rs1),
      .ifid_rs2     (ifid_rs2),
      .branch_taken (branch_taken),
      .dmem_busy    (dmem_busy),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_write   (idex_write),
      .idex_flush   (idex_flush),
      .exmem_write  (exmem_write),
      .exmem_flush  (exmem_flush),
      .mem_timeout  (mem_timeout),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and queue what the
   // outputs must be during that cycle (counters show state before the edge).
   task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic busy,
                       input logic [6:0] ctrl, input logic to,
                       input logic [CW-1:0] sc, input logic [CW-1:0] fc);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst;
      idex_mem_read = mr;
      idex_rd       = rd;
      ifid_rs1      = rs1;
      ifid_rs2      = rs2;
      branch_taken  = br;
      dmem_busy     = busy;
      step_id++;
      e.ctrl = ctrl;
      e.to   = to;
      e.sc   = sc;
      e.fc   = fc;
      e.id   = step_id;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [6:0] ctrl, input logic to,
                       input logic [CW-1:0] sc, input logic [CW-1:0] fc);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ctrl, to, sc, fc);
   endtask

   // Monitor: the controller presents its outputs every cycle.
   initial begin
      exp_t e;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, exmem_flush};
            checks++;
            if (act !== e.ctrl) begin
               errors++;
               $display("FAIL ctrl step %0d: got %b want %b", e.id, act, e.ctrl);
            end
            checks++;
            if (mem_timeout !== e.to) begin
               errors++;
               $display("FAIL mem_timeout step %0d: got %b want %b", e.id, mem_timeout, e.to);
            end
            checks++;
            if (stall_count !== e.sc) begin
               errors++;
               $display("FAIL stall_count step %0d: got %0d want %0d", e.id, stall_count, e.sc);
            end
            checks++;
            if (flush_count !== e.fc) begin
               errors++;
               $display("FAIL flush_count step %0d: got %0d want %0d", e.id, flush_count, e.fc);
            end
         end
      end
   end

   initial begin
      int unsigned sc_exp;
      // Reset held: everything disabled, counters clear.
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FRZ, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FRZ, 1'b0, 4'd0, 4'd0);
      idle(C_DEF, 1'b0, 4'd0, 4'd0);
      // Load-use on rs1, then load leaves EX.
      step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, C_LU, 1'b0, 4'd0, 4'd0);
      idle(C_DEF, 1'b0, 4'd1, 4'd0);
      // x0 destination never stalls.
      step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0, 4'd1, 4'd0);
      // Load-use on rs2.
      step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, C_LU, 1'b0, 4'd1, 4'd0);
      // Register match but not a load.
      step(1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0, 4'd2, 4'd0);
      // Branch wins over load-use.
      step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, C_BR, 1'b0, 4'd2, 4'd0);
      idle(C_DEF, 1'b0, 4'd2, 4'd1);
      // Memory wait with branch held for 3 cycles, then release into the flush.
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, C_FRZ, 1'b0, 4'd2, 4'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, C_FRZ, 1'b0, 4'd3, 4'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, C_FRZ, 1'b0, 4'd4, 4'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR,  1'b0, 4'd5, 4'd1);
      idle(C_DEF, 1'b0, 4'd5, 4'd2);
      // Busy, branch and load-use together: freeze only.
      step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, C_FRZ, 1'b0, 4'd5, 4'd2);
      idle(C_DEF, 1'b0, 4'd6, 4'd2);
      // Busy drops on the TIMEOUT-th cycle: no error.
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd6, 4'd2);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd7, 4'd2);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd8, 4'd2);
      idle(C_DEF, 1'b0, 4'd9, 4'd2);
      idle(C_DEF, 1'b0, 4'd9, 4'd2);
      // 20 consecutive load-use stalls: stall_count saturates at 15.
      sc_exp = 9;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0, C_LU, 1'b0, CW'(sc_exp), 4'd2);
         if (sc_exp < 15) sc_exp++;
      end
      idle(C_DEF, 1'b0, 4'd15, 4'd2);
      // Reset asserted mid MEM_WAIT.
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd15, 4'd2);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd15, 4'd2);
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd15, 4'd2);
      idle(C_DEF, 1'b0, 4'd0, 4'd0);
      // Watchdog: busy held TIMEOUT cycles enters ERROR.
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd0, 4'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd1, 4'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd2, 4'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ, 1'b0, 4'd3, 4'd0);
      idle(C_FRZ, 1'b1, 4'd4, 4'd0);
      // ERROR ignores branch and load-use and stops counting.
      step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, C_FRZ, 1'b1, 4'd4, 4'd0);
      idle(C_FRZ, 1'b1, 4'd4, 4'd0);
      // Reset leaves ERROR.
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FRZ, 1'b1, 4'd4, 4'd0);
      idle(C_DEF, 1'b0, 4'd0, 4'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR, 1'b0, 4'd0, 4'd0);
      idle(C_DEF, 1'b0, 4'd0, 4'd1);

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
